// File: rtl/mul_arb_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: FSM encodings,
// requester ids and the default multicycle window.
package mul_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int DEFAULT_WAIT_CYCLES = 4;

endpackage

// File: rtl/wallace_mul_arbiter_mul.sv
// Combinational 32x32 unsigned Wallace-tree multiplier: 3:2 carry-save layers
// reduce 32 partial products to two rows, then one final carry-propagate add.
module wallace_mul_arbiter_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);

    localparam int ROWS   = 32;
    localparam int LAYERS = 8;

    function automatic int rows_after(input int n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    logic [63:0] pp_s  [ROWS];
    logic [63:0] nxt_s [ROWS];
    int          n_s;

    // Build partial products and reduce them layer by layer (32,22,15,10,7,5,4,3,2)
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            pp_s[r] = b[r] ? (64'(a) << r) : 64'd0;
        end
        n_s = ROWS;
        for (int l = 0; l < LAYERS; l++) begin
            for (int r = 0; r < ROWS; r++) begin
                nxt_s[r] = 64'd0;
            end
            for (int g = 0; g < n_s / 3; g++) begin
                nxt_s[2*g]   = pp_s[3*g] ^ pp_s[3*g+1] ^ pp_s[3*g+2];
                nxt_s[2*g+1] = ((pp_s[3*g] & pp_s[3*g+1]) |
                                (pp_s[3*g] & pp_s[3*g+2]) |
                                (pp_s[3*g+1] & pp_s[3*g+2])) << 1;
            end
            // Rows left over from the last full triple pass straight through
            for (int r = (n_s / 3) * 3; r < n_s; r++) begin
                nxt_s[r - (n_s / 3)] = pp_s[r];
            end
            for (int r = 0; r < ROWS; r++) begin
                pp_s[r] = nxt_s[r];
            end
            n_s = rows_after(n_s);
        end
        product = pp_s[0] + pp_s[1];
    end

endmodule

// File: rtl/wallace_mul_arbiter.sv
// Round-robin arbiter sharing one multicycle Wallace multiplier between two
// requesters; single outstanding operation, product registered after the window.
module wallace_mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [63:0] rsp_data,
    output logic        busy
);

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      rsp_data_q, rsp_data_d;
    logic [63:0]      product_s;
    logic [1:0]       grant_s;

    // a_q/b_q -> product_s is the only multicycle path (WAIT_CYCLES cycles)
    wallace_mul_arbiter_mul u_mul (
        .a       (a_q),
        .b       (b_q),
        .product (product_s)
    );

    // Round-robin grant, offered only while idle; a tie goes to the requester not served last
    always_comb begin
        grant_s = 2'b00;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = (last_grant_q == REQ1) ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    // FSM, operand capture and wait counter
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (grant_s[1]) begin
                    a_d          = req_a1;
                    b_d          = req_b1;
                    owner_d      = REQ1;
                    last_grant_d = REQ1;
                    cnt_d        = CNT_W'(WAIT_CYCLES - 1);
                    state_d      = BUSY;
                end else if (grant_s[0]) begin
                    a_d          = req_a0;
                    b_d          = req_b0;
                    owner_d      = REQ0;
                    last_grant_d = REQ0;
                    cnt_d        = CNT_W'(WAIT_CYCLES - 1);
                    state_d      = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    rsp_data_d = product_s;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            owner_q      <= REQ0;
            last_grant_q <= REQ1;
            cnt_q        <= {CNT_W{1'b0}};
            rsp_data_q   <= 64'd0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = (state_q == DONE) ? ((owner_q == REQ1) ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule
